move_exec_arbiter: RTL and testbench

MOVE_EXEC_ARBITER -- requirements
Module: move_exec_arbiter

---
 rtl/move_exec_arbiter.sv | 136 +++++++++++++
 tb/tb_move_exec_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/move_exec_arbiter.sv
// Two-port round-robin arbiter that serialises move requests onto one board executor.
// One transaction is outstanding at a time; a silent executor yields the input board with err set.
module move_exec_arbiter #(
  parameter int unsigned MOVE_W  = 16,
  parameter int unsigned BOARD_W = 428,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk_in,
  input  logic               rst_in,

  input  logic [MOVE_W-1:0]  req0_move,
  input  logic [BOARD_W-1:0] req0_board,
  input  logic               req0_valid,
  output logic               req0_ready,

  input  logic [MOVE_W-1:0]  req1_move,
  input  logic [BOARD_W-1:0] req1_board,
  input  logic               req1_valid,
  output logic               req1_ready,

  output logic [BOARD_W-1:0] rsp0_board,
  output logic               rsp0_valid,
  output logic               rsp0_err,

  output logic [BOARD_W-1:0] rsp1_board,
  output logic               rsp1_valid,
  output logic               rsp1_err,

  output logic [MOVE_W-1:0]  exec_move,
  output logic [BOARD_W-1:0] exec_board,
  output logic               exec_valid,
  input  logic [BOARD_W-1:0] exec_result,
  input  logic               exec_result_valid,

  output logic               busy
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StRespond
  } state_e;

  // Counter value seen on the last WAIT cycle before the timeout fires.
  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  state_e      state_q;
  logic        last_grant_q;
  logic        grant_q;
  logic [15:0] cnt_q;

  logic tie;
  logic grant_sel;
  logic accept;
  logic timed_out;

  always_comb begin
    tie        = req0_valid & req1_valid;
    // On a tie the port not served last wins; otherwise whichever port is requesting.
    grant_sel  = tie ? ~last_grant_q : req1_valid;
    req0_ready = (state_q == StIdle) & req0_valid & ~grant_sel;
    req1_ready = (state_q == StIdle) & req1_valid & grant_sel;
    accept     = req0_ready | req1_ready;
    timed_out  = (cnt_q == CntLast);
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      exec_valid   <= 1'b0;
      exec_move    <= '0;
      exec_board   <= '0;
      rsp0_valid   <= 1'b0;
      rsp0_err     <= 1'b0;
      rsp0_board   <= '0;
      rsp1_valid   <= 1'b0;
      rsp1_err     <= 1'b0;
      rsp1_board   <= '0;
    end else begin
      exec_valid <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            grant_q      <= grant_sel;
            last_grant_q <= grant_sel;
            exec_move    <= grant_sel ? req1_move : req0_move;
            exec_board   <= grant_sel ? req1_board : req0_board;
            exec_valid   <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q + 16'd1;
          // A result arriving on the expiry cycle still wins over the timeout.
          if (exec_result_valid || timed_out) begin
            state_q <= StRespond;
            if (grant_q) begin
              rsp1_valid <= 1'b1;
              rsp1_board <= exec_result_valid ? exec_result : exec_board;
              rsp1_err   <= ~exec_result_valid;
            end else begin
              rsp0_valid <= 1'b1;
              rsp0_board <= exec_result_valid ? exec_result : exec_board;
              rsp0_err   <= ~exec_result_valid;
            end
          end
        end
        StRespond: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  a_exec_in_issue: assert property (@(posedge clk_in) disable iff (rst_in)
    exec_valid |-> (state_q == StIssue));

  a_rsp_exclusive: assert property (@(posedge clk_in) disable iff (rst_in)
    !(rsp0_valid && rsp1_valid));

endmodule

// File: tb/tb_move_exec_arbiter.sv
// Randomised bench for move_exec_arbiter against a transaction-timeline reference model.
module tb_move_exec_arbiter;

  localparam int MW = 16;
  localparam int BW = 428;
  localparam int TO = 4;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [MW-1:0] req0_move = '0, req1_move = '0;
  logic [BW-1:0] req0_board = '0, req1_board = '0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [BW-1:0] rsp0_board, rsp1_board;
  logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [MW-1:0] exec_move;
  logic [BW-1:0] exec_board;
  logic          exec_valid;
  logic [BW-1:0] exec_result = '0;
  logic          exec_result_valid = 1'b0;
  logic          busy;

  always #5 clk_in = ~clk_in;

  move_exec_arbiter #(
    .MOVE_W (MW),
    .BOARD_W(BW),
    .TIMEOUT(TO)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .req0_move        (req0_move),
    .req0_board       (req0_board),
    .req0_valid       (req0_valid),
    .req0_ready       (req0_ready),
    .req1_move        (req1_move),
    .req1_board       (req1_board),
    .req1_valid       (req1_valid),
    .req1_ready       (req1_ready),
    .rsp0_board       (rsp0_board),
    .rsp0_valid       (rsp0_valid),
    .rsp0_err         (rsp0_err),
    .rsp1_board       (rsp1_board),
    .rsp1_valid       (rsp1_valid),
    .rsp1_err         (rsp1_err),
    .exec_move        (exec_move),
    .exec_board       (exec_board),
    .exec_valid       (exec_valid),
    .exec_result      (exec_result),
    .exec_result_valid(exec_result_valid),
    .busy             (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_board();
    logic [BW-1:0] b = '0;
    for (int i = 0; i < (BW + 31) / 32; i++) b = {b[BW-33:0], $urandom()};
    return b;
  endfunction

  // Reference model: one transaction described by its accept and respond cycles.
  int            cyc = 0;
  bit            act = 0;
  int            t_port, t_a, t_r;
  logic [BW-1:0] t_rsp_board;
  logic          t_err;
  int            last_srv = 1;
  logic [MW-1:0] lat_move = '0;
  logic [BW-1:0] lat_board = '0;
  logic [BW-1:0] m_rsp_board[2] = '{default: '0};
  logic          m_rsp_err[2] = '{1'b0, 1'b0};
  bit            pend[2] = '{0, 0};
  logic [MW-1:0] p_move[2] = '{default: '0};
  logic [BW-1:0] p_board[2] = '{default: '0};
  int            pulse_cyc = -1;
  logic [BW-1:0] pulse_val = '0;
  int            gen_pct[2] = '{0, 0};
  int            force_k = -1;
  bit            spur_en = 0;
  bit            record = 0;
  int            served[$];

  task automatic inject(input int p, input logic [MW-1:0] mv);
    pend[p]    = 1;
    p_move[p]  = mv;
    p_board[p] = rand_board();
  endtask

  task automatic step();
    bit            in_wait;
    int            w;
    int            k;
    logic [BW-1:0] rdata;
    @(posedge clk_in);
    #1;
    cyc++;
    if (act && cyc > t_r) act = 0;
    for (int p = 0; p < 2; p++) begin
      if (!pend[p] && int'($urandom_range(99)) < gen_pct[p]) inject(p, MW'($urandom()));
    end
    req0_valid = pend[0]; req0_move = p_move[0]; req0_board = p_board[0];
    req1_valid = pend[1]; req1_move = p_move[1]; req1_board = p_board[1];
    in_wait = act && cyc >= t_a + 2 && cyc < t_r;
    rdata = rand_board();
    exec_result_valid = 1'b0;
    if (cyc == pulse_cyc) begin
      exec_result_valid = 1'b1;
      rdata = pulse_val;
    end else if (spur_en && !in_wait && $urandom_range(7) == 0) begin
      exec_result_valid = 1'b1;
    end
    exec_result = rdata;

    w = -1;
    if (!act) begin
      if (pend[0] && pend[1]) w = (last_srv == 1) ? 0 : 1;
      else if (pend[0]) w = 0;
      else if (pend[1]) w = 1;
    end
    if (act && cyc == t_r) begin
      m_rsp_board[t_port] = t_rsp_board;
      m_rsp_err[t_port]   = t_err;
    end

    @(negedge clk_in);
    check("busy", BW'(busy), BW'(act));
    check("req0_ready", BW'(req0_ready), BW'(w == 0));
    check("req1_ready", BW'(req1_ready), BW'(w == 1));
    check("exec_valid", BW'(exec_valid), BW'(act && cyc == t_a + 1));
    check("exec_move", BW'(exec_move), BW'(lat_move));
    check("exec_board", exec_board, lat_board);
    check("rsp0_valid", BW'(rsp0_valid), BW'(act && cyc == t_r && t_port == 0));
    check("rsp1_valid", BW'(rsp1_valid), BW'(act && cyc == t_r && t_port == 1));
    check("rsp0_board", rsp0_board, m_rsp_board[0]);
    check("rsp1_board", rsp1_board, m_rsp_board[1]);
    check("rsp0_err", BW'(rsp0_err), BW'(m_rsp_err[0]));
    check("rsp1_err", BW'(rsp1_err), BW'(m_rsp_err[1]));
    if (record && rsp0_valid) served.push_back(0);
    if (record && rsp1_valid) served.push_back(1);

    if (w >= 0) begin
      pend[w]   = 0;
      act       = 1;
      t_a       = cyc;
      t_port    = w;
      last_srv  = w;
      lat_move  = p_move[w];
      lat_board = p_board[w];
      k = (force_k >= 0) ? force_k : int'($urandom_range(TO + 3, 2));
      pulse_val = rand_board();
      pulse_cyc = (k <= TO + 3) ? cyc + k : -1;
      if (k <= TO + 1) begin
        t_r = cyc + k + 1; t_rsp_board = pulse_val; t_err = 1'b0;
      end else begin
        t_r = cyc + TO + 2; t_rsp_board = p_board[w]; t_err = 1'b1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    gen_pct = '{0, 0};
    spur_en = 0;
    while ((act || pend[0] || pend[1] || cyc <= pulse_cyc) && n < 200) begin
      step();
      n++;
    end
    check("drain_bound", BW'(n < 200), BW'(1));
  endtask

  task automatic apply_reset(input bit pulse_after);
    @(posedge clk_in);
    #2;
    rst_in = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exec_result_valid = 1'b0;
    #1;
    check("rst_busy", BW'(busy), '0);
    check("rst_exec_valid", BW'(exec_valid), '0);
    check("rst_exec_move", BW'(exec_move), '0);
    check("rst_exec_board", exec_board, '0);
    check("rst_rsp0_valid", BW'(rsp0_valid), '0);
    check("rst_rsp1_valid", BW'(rsp1_valid), '0);
    check("rst_rsp0_err", BW'(rsp0_err), '0);
    check("rst_rsp1_err", BW'(rsp1_err), '0);
    check("rst_rsp0_board", rsp0_board, '0);
    check("rst_rsp1_board", rsp1_board, '0);
    act = 0; pend = '{0, 0}; last_srv = 1; pulse_cyc = -1;
    lat_move = '0; lat_board = '0;
    m_rsp_board = '{default: '0}; m_rsp_err = '{1'b0, 1'b0};
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    exec_result_valid = pulse_after;
    exec_result = rand_board();
  endtask

  initial begin
    int n;
    apply_reset(1'b0);

    // Both ports requesting from reset: expect 0, 1, 0.
    gen_pct = '{100, 100}; force_k = 2; record = 1;
    repeat (13) step();
    record = 0;
    check("tie_count", BW'(served.size() >= 3), BW'(1));
    for (int i = 0; i < 3; i++) begin
      if (i < served.size()) check($sformatf("tie_order%0d", i), BW'(served[i]), BW'(i % 2));
    end

    drain(); force_k = 3;      inject(0, 16'h0C1C); repeat (8) step();
    drain(); force_k = 100;    inject(1, MW'($urandom())); repeat (10) step();
    drain(); force_k = TO + 1; inject(0, MW'($urandom())); repeat (9) step();
    drain(); force_k = TO + 2; inject(1, MW'($urandom())); repeat (10) step();

    // Reset in the middle of WAIT, then a stale executor result.
    drain(); force_k = 100; inject(1, MW'($urandom()));
    n = 0;
    while (!(act && cyc == t_a + 3) && n < 20) begin
      step();
      n++;
    end
    check("reach_wait", BW'(n < 20), BW'(1));
    apply_reset(1'b1);
    force_k = 2; inject(0, MW'($urandom())); repeat (8) step();

    // Spurious executor results while idle.
    drain(); spur_en = 1; repeat (30) step();

    gen_pct = '{35, 35}; force_k = -1; spur_en = 1;
    repeat (3000) step();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
